// File: rtl/dcache_pkg.sv
// dcache_pkg: address-field geometry and FSM encoding shared by the L1 data cache
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W = 5;
  localparam int TAG_W = 22;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_LSB = 2;
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB = OFFSET_W + INDEX_W;
  typedef enum logic [1:0] {IDLE, MISS, WRITEBACK, ALLOCATE} state_t;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/data/valid/dirty arrays with async read, line refill and word-merge writes
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    index_i,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  valid_o,
  output logic                  dirty_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [31:0]           word_i
);
  logic [TAG_W-1:0] tag_mem [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  assign tag_o = tag_mem[index_i];
  assign line_o = data_mem[index_i];
  assign valid_o = valid[index_i];
  assign dirty_o = dirty[index_i];
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_mem[index_i] <= line_i;
      tag_mem[index_i] <= line_tag_i;
    end else if (word_we_i) data_mem[index_i][{word_sel_i, 5'b0} +: 32] <= word_i;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we_i) begin
      valid[index_i] <= 1'b1;
      dirty[index_i] <= 1'b0;
    end else if (word_we_i) dirty[index_i] <= 1'b1;
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back/write-allocate L1 D-cache with stall-on-miss FSM
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  state_t state, next;
  logic [TAG_W-1:0] req_tag, vic_tag;
  logic [INDEX_W-1:0] index;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [LINE_BITS-1:0] line;
  logic valid, dirty, req, hit, idle, unused_ok;
  assign req_tag = cpu_addr_i[TAG_LSB +: TAG_W];
  assign index = cpu_addr_i[INDEX_LSB +: INDEX_W];
  assign word_sel = cpu_addr_i[WORD_LSB +: WORD_SEL_W];
  assign unused_ok = ^cpu_addr_i[WORD_LSB-1:0];
  assign req = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit = req & valid & (vic_tag == req_tag);
  assign idle = state == IDLE;
  dcache_sram #(.NUM_LINES(NUM_LINES), .LINE_BITS(LINE_BITS)) u_sram (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .index_i(index),
    .tag_o(vic_tag),
    .line_o(line),
    .valid_o(valid),
    .dirty_o(dirty),
    .line_we_i(state == ALLOCATE && mem_ack_i),
    .line_tag_i(req_tag),
    .line_i(mem_data_i),
    .word_we_i(idle && hit && cpu_MemWrite_i),
    .word_sel_i(word_sel),
    .word_i(cpu_data_i)
  );
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = idle ? (req && !hit ? MISS : IDLE) :
           state == MISS ? (valid && dirty ? WRITEBACK : ALLOCATE) :
           mem_ack_i ? (state == WRITEBACK ? ALLOCATE : IDLE) : state;
  end
  // rst_i gates the CPU-facing outputs so they clear even while a request is still held
  assign cpu_stall_o = rst_i & (!idle | (req & !hit));
  assign cpu_data_o = (rst_i && idle && hit && !cpu_MemWrite_i) ? line[{word_sel, 5'b0} +: 32] : '0;
  assign mem_enable_o = state == WRITEBACK || state == ALLOCATE;
  assign mem_write_o = state == WRITEBACK;
  assign mem_addr_o = mem_enable_o ? {mem_write_o ? vic_tag : req_tag, index, 5'b0} : '0;
  assign mem_data_o = mem_write_o ? line : '0;
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed plus random accesses checked against a transaction-level cache model
module tb_dcache_controller;
  localparam int L = 10;
  logic clk_i = 0, rst_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o, mem_addr_o;
  logic cpu_MemRead_i = 0, cpu_MemWrite_i = 0, cpu_stall_o;
  logic [255:0] mem_data_o, mem_data_i = '0;
  logic mem_enable_o, mem_write_o, mem_ack_i = 0;
  dcache_controller dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i),
    .cpu_MemRead_i(cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );
  always #5 clk_i = ~clk_i;
  int errors = 0, checks = 0, unstable = 0;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic wr; logic [31:0] addr; logic [255:0] data;} txn_t;
  txn_t log_q[$];
  txn_t exp_q[$];
  logic [255:0] phys [logic [26:0]];
  logic [255:0] ref_mem [logic [26:0]];
  function automatic logic [255:0] init_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = {la[20:0], 8'hA5, 3'(w)};
    return l;
  endfunction
  function automatic logic [255:0] phys_line(input logic [26:0] la);
    return phys.exists(la) ? phys[la] : init_line(la);
  endfunction
  function automatic logic [255:0] ref_line_of(input logic [26:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction
  // memory: acks L cycles after a request is seen, and keeps counting even if the requester vanishes
  initial begin
    int cnt;
    bit busy;
    txn_t cur;
    cnt = 0;
    busy = 0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 0;
      if (busy) begin
        cnt++;
        if (mem_enable_o && (mem_addr_o !== cur.addr || mem_write_o !== cur.wr || (cur.wr && mem_data_o !== cur.data)))
          unstable++;
        if (cnt == L) begin
          busy = 0;
          mem_ack_i = 1;
          if (cur.wr) phys[cur.addr[31:5]] = cur.data;
          else mem_data_i = phys_line(cur.addr[31:5]);
        end
      end else if (mem_enable_o) begin
        busy = 1;
        cnt = 1;
        cur = txn_t'({mem_write_o, mem_addr_o, mem_data_o});
        log_q.push_back(cur);
      end
    end
  end
  bit ref_valid[32], ref_dirty[32];
  logic [21:0] ref_tag[32];
  logic [255:0] ref_line[32];
  int exp_stall;
  logic [31:0] exp_rdata;
  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int idx, w;
    logic [21:0] tag;
    logic [26:0] la;
    idx = int'((a >> 5) % 32);
    w = int'((a >> 2) % 8);
    tag = 22'(a >> 10);
    la = 27'(a >> 5);
    exp_q.delete();
    exp_stall = 0;
    exp_rdata = 0;
    if (!(rd || wr)) return;
    if (!(ref_valid[idx] && ref_tag[idx] == tag)) begin
      exp_stall = L + 2;
      if (ref_dirty[idx]) begin
        exp_q.push_back(txn_t'({1'b1, ref_tag[idx], 5'(idx), 5'b0, ref_line[idx]}));
        ref_mem[{ref_tag[idx], 5'(idx)}] = ref_line[idx];
        exp_stall += L;
      end
      exp_q.push_back(txn_t'({1'b0, la, 5'b0, 256'b0}));
      ref_line[idx] = ref_line_of(la);
      ref_tag[idx] = tag;
      ref_valid[idx] = 1;
      ref_dirty[idx] = 0;
    end
    if (wr) begin
      ref_line[idx][w*32 +: 32] = d;
      ref_dirty[idx] = 1;
    end else exp_rdata = ref_line[idx][w*32 +: 32];
  endtask
  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int cyc, base, n;
    model(rd, wr, a, d);
    base = log_q.size();
    cyc = 0;
    @(negedge clk_i);
    cpu_addr_i = a;
    cpu_data_i = d;
    cpu_MemRead_i = rd;
    cpu_MemWrite_i = wr;
    #1;
    while (cpu_stall_o && cyc < 200) begin
      @(negedge clk_i);
      #1;
      cyc++;
    end
    check({tag, " stall"}, cyc, exp_stall);
    check({tag, " rdata"}, cpu_data_o, exp_rdata);
    n = log_q.size() - base;
    check({tag, " ntxn"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check({tag, " txn wr"}, log_q[base+i].wr, exp_q[i].wr);
      check({tag, " txn addr"}, log_q[base+i].addr, exp_q[i].addr);
      check({tag, " txn data"}, log_q[base+i].data, exp_q[i].data);
    end
    @(negedge clk_i);
    cpu_MemRead_i = 0;
    cpu_MemWrite_i = 0;
  endtask
  initial begin
    logic seen;
    int cyc;
    logic [31:0] a;
    int r;
    cpu_MemRead_i = 1;
    cpu_addr_i = 32'h400;
    #12;
    check("reset stall", cpu_stall_o, 0);
    check("reset enable", mem_enable_o, 0);
    check("reset write", mem_write_o, 0);
    check("reset addr", mem_addr_o, 0);
    check("reset rdata", cpu_data_o, 0);
    cpu_MemRead_i = 0;
    @(negedge clk_i);
    rst_i = 1;
    do_op("cold rd", 1, 0, 32'h400, 0);
    do_op("hit rd", 1, 0, 32'h41C, 0);
    do_op("wr hit", 0, 1, 32'h404, 32'hDEADBEEF);
    do_op("rd back", 1, 0, 32'h404, 0);
    do_op("dirty conflict", 1, 0, 32'h804, 0);
    do_op("wr miss", 0, 1, 32'hC08, 32'h12345678);
    do_op("evict", 1, 0, 32'h008, 0);
    do_op("rd+wr", 1, 1, 32'h00C, 32'hCAFEF00D);
    do_op("rd after rw", 1, 0, 32'h00C, 0);
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      do_op("rnd", r != 2, r >= 2, a, $urandom);
    end
    model(1, 0, 32'h1400, 0);
    foreach (ref_valid[i]) begin
      ref_valid[i] = 0;
      ref_dirty[i] = 0;
    end
    @(negedge clk_i);
    cpu_addr_i = 32'h1400;
    cpu_MemRead_i = 1;
    cyc = 0;
    while (!(mem_enable_o && !mem_write_o) && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    check("refill seen", cyc < 40, 1);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 0;
    #1;
    check("mid rst stall", cpu_stall_o, 0);
    check("mid rst enable", mem_enable_o, 0);
    check("mid rst addr", mem_addr_o, 0);
    cpu_MemRead_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk_i);
      #1;
      if (mem_enable_o || cpu_stall_o) seen = 1;
    end
    check("late ack ignored", seen, 0);
    do_op("reread", 1, 0, 32'h1400, 0);
    check("req stable", unstable, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data-cache controller between the CPU MEM stage and the off-chip data memory.
- Accepts word read/write requests from the MEM stage (MemRead/MemWrite produced by the main decoder).
- Hits are served combinationally. Misses drive cpu_stall_o to freeze the pipeline while a dirty-victim writeback and/or a line refill are sequenced over a request/ack memory handshake.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width
- NUM_LINES, 32, cache lines (index width = log2 = 5)
- LINE_BITS, 256, line size in bits (32 bytes; offset width 5; 8 words)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_addr_i  in  32  byte address; bits[1:0] ignored
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  pipeline freeze
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  writeback line
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1 = write line, 0 = read line
- mem_data_i  in  256  refill line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address fields: offset[4:0], word select [4:2], index[9:5], tag[31:10] (22 bits).
- req = MemRead | MemWrite. If both are asserted, the request is treated as a write.
- hit = req & valid[index] & (tag[index] == addr tag).
- States: IDLE, MISS, WRITEBACK, ALLOCATE.
- IDLE, read hit: cpu_data_o = selected word, same cycle. cpu_stall_o = 0.
- IDLE, write hit: at the clock edge, merge the word into the line and set dirty. cpu_stall_o = 0.
- IDLE, miss: cpu_stall_o = 1 combinationally; next state MISS.
- MISS (1 cycle, no memory request):
  - victim valid & dirty -> WRITEBACK.
  - otherwise -> ALLOCATE.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - On mem_ack_i -> ALLOCATE.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: write mem_data_i into the line, tag = req tag, valid = 1, dirty = 0 -> IDLE.
  - IDLE then re-evaluates the request as a hit. A pending store merges on that cycle and sets dirty.
- cpu_stall_o = (state != IDLE) | (IDLE & req & ~hit).
- cpu_data_o = 0 when not (IDLE & read hit).
- mem_enable_o, mem_write_o, mem_addr_o, mem_data_o are registered/derived from state and are 0 outside WRITEBACK/ALLOCATE.
- Memory handshake:
  - Request fields stay stable while mem_enable_o = 1.
  - Earliest ack is the cycle after enable first rises.
  - Ack outside WRITEBACK/ALLOCATE is ignored.
  - Enable deasserts the cycle after ack (WRITEBACK->ALLOCATE keeps enable high with changed fields).
- Latency: with L = cycles from enable rise to ack inclusive:
  - clean miss stalls L+2 cycles;
  - dirty miss stalls Lw+Lr+2 cycles.
- CPU inputs must stay stable while stalled; the controller re-samples them in IDLE.
- Reset (asynchronous, any state):
  - state = IDLE; all valid and dirty bits = 0.
  - All outputs go to 0 immediately.
  - Any outstanding memory transaction is abandoned; a late ack is ignored.
  - Data and tag arrays are not reset.

Decomposition:
- Package dcache_pkg: state encoding (IDLE, MISS, WRITEBACK, ALLOCATE), OFFSET_W = 5, INDEX_W = 5, TAG_W = 22, WORD_SEL_W = 3, address-field slice constants.
- Sub-module dcache_sram:
  - tag, data, valid and dirty arrays.
  - Asynchronous read, synchronous write.
  - Full-line write and word-merge write ports.
  - Valid/dirty cleared by asynchronous active-low reset.
- The controller contains the FSM, hit compare and output muxing.

Test Plan:
- Memory model: ack latency 10.
- Cold read: after reset, read 0x400 -> stall 12 cycles, one read request at 0x400, cpu_data_o = memory word 0 of that line, then stall drops.
- Read hit: read 0x41C on the next cycle -> no stall, word 7 returned the same cycle, no mem_enable_o.
- Write hit: write 0x404 = 0xDEADBEEF -> no stall; a subsequent read of 0x404 returns 0xDEADBEEF with no memory traffic.
- Dirty conflict: read 0x804 (index 0, new tag) -> writeback at 0x400 with word 1 = 0xDEADBEEF, then read at 0x800; stall 22 cycles; correct word returned.
- Write miss, clean victim: write 0xC08 = 0x12345678 -> refill only (no writeback); then evicting via read 0x008 produces a writeback at 0xC00 containing 0x12345678.
- Reset mid-ALLOCATE: assert rst_i low 5 cycles into a refill -> mem_enable_o and cpu_stall_o drop immediately; a late ack is ignored; re-reading the same address misses again.
